// File: rtl/cr_sys_lpmd_ctrl_pkg.sv
// Shared types and constants for the E902 low-power-mode sequencer.
// Holds the state encoding, lpmd_b codes and the default ack timeout width.
package cr_lpmd_pkg;

    localparam int ACK_TO_W_DFLT = 8;

    localparam logic [1:0] LPMD_RUN  = 2'b11;
    localparam logic [1:0] LPMD_WAIT = 2'b10;
    localparam logic [1:0] LPMD_DOZE = 2'b01;
    localparam logic [1:0] LPMD_STOP = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REQ,
        ST_SLEEP,
        ST_WAKE,
        ST_FIN
    } lpmd_st_e;

endpackage

// File: rtl/cr_sys_lpmd_ctrl_if.sv
// Bundle between CP0/IU/power controller and the lpmd sequencer.
// slave is the sequencer side, master is the surrounding system.
interface cr_sys_lpmd_ctrl_if;

    logic       cp0_lpmd_req;
    logic [1:0] cp0_lpmd_mode;
    logic       iu_pipe_idle;
    logic       iu_sys_lp_wk_int;
    logic       had_yy_xx_dbg;
    logic       pad_lpmd_ack;
    logic [1:0] lpc_lpmd_b;
    logic       lpc_iu_stall;
    logic       lpc_cp0_done;
    logic       lpc_cp0_abort;
    logic       lpc_clk_req;

    modport slave (
        input  cp0_lpmd_req,
        input  cp0_lpmd_mode,
        input  iu_pipe_idle,
        input  iu_sys_lp_wk_int,
        input  had_yy_xx_dbg,
        input  pad_lpmd_ack,
        output lpc_lpmd_b,
        output lpc_iu_stall,
        output lpc_cp0_done,
        output lpc_cp0_abort,
        output lpc_clk_req
    );

    modport master (
        output cp0_lpmd_req,
        output cp0_lpmd_mode,
        output iu_pipe_idle,
        output iu_sys_lp_wk_int,
        output had_yy_xx_dbg,
        output pad_lpmd_ack,
        input  lpc_lpmd_b,
        input  lpc_iu_stall,
        input  lpc_cp0_done,
        input  lpc_cp0_abort,
        input  lpc_clk_req
    );

endinterface

// File: rtl/cr_sys_lpmd_ctrl_ack_timer.sv
// Saturating acknowledge-timeout counter for the lpmd sequencer.
// term is high once the counter reaches all-ones; it never wraps.
module cr_lpmd_ack_timer #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clk_en,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [W-1:0] cnt;

    assign term = &cnt;

    // clear wins over increment; counting stops at all-ones
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clk_en) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc && !term) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cr_sys_lpmd_ctrl.sv
// Low-power-mode entry/exit sequencer between CP0/IU and sysio lpmd regs.
// Drains the pipe, presents lpmd_b, handshakes with the power controller.
module cr_sys_lpmd_ctrl
    import cr_lpmd_pkg::*;
#(
    parameter int ACK_TO_W = ACK_TO_W_DFLT
) (
    input logic            sysio_lpmd_gated_clk,
    input logic            cpurst_b,
    input logic            clk_en,
    cr_sys_lpmd_ctrl_if.slave bus
);

    lpmd_st_e   state;
    lpmd_st_e   state_nx;
    logic [1:0] mode_q;
    logic [1:0] mode_nx;
    logic       abt_q;
    logic       abt_nx;
    logic [1:0] lpmd_q;
    logic       stall_q;
    logic       done_q;
    logic       abort_q;
    logic       to_clr;
    logic       to_inc;
    logic       to_term;
    logic       wake;

    assign wake = bus.iu_sys_lp_wk_int | bus.had_yy_xx_dbg;

    cr_lpmd_ack_timer #(
        .W(ACK_TO_W)
    ) u_timer (
        .clk    (sysio_lpmd_gated_clk),
        .rst_b  (cpurst_b),
        .clk_en (clk_en),
        .clr    (to_clr),
        .inc    (to_inc),
        .term   (to_term)
    );

    // next-state decode; wake beats pipe-idle and ack, ack beats timeout
    always_comb begin
        state_nx = state;
        mode_nx  = mode_q;
        abt_nx   = abt_q;
        to_clr   = 1'b0;
        to_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.cp0_lpmd_req &&
                    bus.cp0_lpmd_mode != LPMD_RUN) begin
                    mode_nx  = bus.cp0_lpmd_mode;
                    abt_nx   = 1'b0;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wake) begin
                    abt_nx   = 1'b1;
                    state_nx = ST_FIN;
                end else if (bus.iu_pipe_idle) begin
                    to_clr   = 1'b1;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wake) begin
                    state_nx = ST_WAKE;
                end else if (bus.pad_lpmd_ack) begin
                    state_nx = ST_SLEEP;
                end else if (to_term) begin
                    abt_nx   = 1'b1;
                    state_nx = ST_WAKE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (wake) begin
                    state_nx = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (!bus.pad_lpmd_ack) begin
                    state_nx = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // state and registered outputs; pulses only on enabled FIN cycles
    always_ff @(posedge sysio_lpmd_gated_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state   <= ST_IDLE;
            mode_q  <= LPMD_RUN;
            abt_q   <= 1'b0;
            lpmd_q  <= LPMD_RUN;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= clk_en && state == ST_FIN && !abt_q;
            abort_q <= clk_en && state == ST_FIN && abt_q;
            if (clk_en) begin
                state   <= state_nx;
                mode_q  <= mode_nx;
                abt_q   <= abt_nx;
                stall_q <= state_nx != ST_IDLE;
                lpmd_q  <= (state_nx == ST_REQ ||
                            state_nx == ST_SLEEP) ? mode_nx : LPMD_RUN;
            end
        end
    end

    assign bus.lpc_lpmd_b    = lpmd_q;
    assign bus.lpc_iu_stall  = stall_q;
    assign bus.lpc_cp0_done  = done_q;
    assign bus.lpc_cp0_abort = abort_q;
    assign bus.lpc_clk_req   = (state != ST_IDLE) | bus.cp0_lpmd_req;

endmodule

// File: tb/tb_cr_sys_lpmd_ctrl.sv
// Testbench for cr_sys_lpmd_ctrl: per-cycle vector table with expectations.
// Expected outputs are queued when a row is driven and popped when sampled.
module tb_cr_sys_lpmd_ctrl;
    import cr_lpmd_pkg::*;

    typedef struct {
        int         sec;
        logic       rst;
        logic       en;
        logic       req;
        logic [1:0] mode;
        logic       idle;
        logic       wk;
        logic       dbg;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic cpurst_b;
    logic clk_en;
    int   checks = 0;
    int   errors = 0;

    vec_t       tbl[$];
    string      sn[$];
    logic [5:0] sb[$];

    cr_sys_lpmd_ctrl_if bus();

    cr_sys_lpmd_ctrl #(
        .ACK_TO_W(4)
    ) dut (
        .sysio_lpmd_gated_clk (clk),
        .cpurst_b             (cpurst_b),
        .clk_en               (clk_en),
        .bus                  (bus)
    );

    always #5 clk = ~clk;

    function automatic void sec(string s);
        sn.push_back(s);
    endfunction

    // n copies of one row: inputs, then lpmd_b, stall, done, abort, clk_req
    function automatic void add(
        int n, bit rst, bit en, bit req, bit [1:0] mode,
        bit idle, bit wk, bit dbg, bit ack,
        bit [1:0] lp, bit st, bit dn, bit ab, bit cr
    );
        vec_t v;
        v.sec  = sn.size() - 1;
        v.rst  = rst;
        v.en   = en;
        v.req  = req;
        v.mode = mode;
        v.idle = idle;
        v.wk   = wk;
        v.dbg  = dbg;
        v.ack  = ack;
        v.exp  = {lp, st, dn, ab, cr};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic step(input vec_t v, input int row);
        logic [5:0] got;
        logic [5:0] e;
        cpurst_b             = !v.rst;
        clk_en               = v.en;
        bus.cp0_lpmd_req     = v.req;
        bus.cp0_lpmd_mode    = v.mode;
        bus.iu_pipe_idle     = v.idle;
        bus.iu_sys_lp_wk_int = v.wk;
        bus.had_yy_xx_dbg    = v.dbg;
        bus.pad_lpmd_ack     = v.ack;
        sb.push_back(v.exp);
        @(negedge clk);
        got = {bus.lpc_lpmd_b, bus.lpc_iu_stall, bus.lpc_cp0_done,
               bus.lpc_cp0_abort, bus.lpc_clk_req};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s row %0d got %b exp %b (lpmd,stall,done,abort,clkreq)",
                     sn[v.sec], row, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cpurst_b             = 1'b0;
        clk_en               = 1'b1;
        bus.cp0_lpmd_req     = 1'b0;
        bus.cp0_lpmd_mode    = LPMD_RUN;
        bus.iu_pipe_idle     = 1'b1;
        bus.iu_sys_lp_wk_int = 1'b0;
        bus.had_yy_xx_dbg    = 1'b0;
        bus.pad_lpmd_ack     = 1'b0;

        sec("reset");
        add(2, 1,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("ignore_run");
        add(2, 0,1,1,2'b11,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("doze");
        add(1, 0,1,1,2'b01,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(2, 0,1,0,2'b11,1,0,0,0, 2'b01,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,1, 2'b01,1,0,0,1);
        add(9, 0,1,0,2'b11,1,0,0,1, 2'b01,1,0,0,1);
        add(1, 0,1,0,2'b11,1,1,0,1, 2'b01,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,1, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,1,0,0);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("drain_abort");
        add(1, 0,1,1,2'b00,0,0,0,0, 2'b11,0,0,0,1);
        add(2, 0,1,0,2'b11,0,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,1,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,1,0);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("ack_timeout");
        add(1, 0,1,1,2'b00,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(16,0,1,0,2'b11,1,0,0,0, 2'b00,1,0,0,1);
        add(2, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,1,0);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("ack_and_wake");
        add(1, 0,1,1,2'b10,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,1,0,1, 2'b10,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,1, 2'b11,1,0,0,1);
        add(2, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,1,0,0);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("clk_en_gaps");
        add(1, 0,0,1,2'b01,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,1,2'b01,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,0,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,0,0,2'b11,1,0,0,0, 2'b01,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b01,1,0,0,1);
        add(1, 0,0,0,2'b11,1,0,0,1, 2'b01,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,1, 2'b01,1,0,0,1);
        add(1, 0,0,0,2'b11,1,1,0,1, 2'b01,1,0,0,1);
        add(1, 0,1,0,2'b11,1,1,0,1, 2'b01,1,0,0,1);
        add(1, 0,0,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(2, 0,0,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,0,0,2'b11,1,0,0,0, 2'b11,0,1,0,0);
        add(1, 0,0,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("timeout_gaps");
        add(1, 0,1,1,2'b00,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        for (int i = 0; i < 16; i++) begin
            add(1, 0,0,0,2'b11,1,0,0,0, 2'b00,1,0,0,1);
            add(1, 0,1,0,2'b11,1,0,0,0, 2'b00,1,0,0,1);
        end
        add(2, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,1,0);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("reset_in_sleep");
        add(1, 0,1,1,2'b10,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(3, 0,1,0,2'b11,1,0,0,1, 2'b10,1,0,0,1);
        add(2, 1,1,0,2'b11,1,0,0,1, 2'b11,0,0,0,0);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        sec("wait_after_reset");
        add(1, 0,1,1,2'b10,1,0,0,0, 2'b11,0,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(2, 0,1,0,2'b11,1,0,0,1, 2'b10,1,0,0,1);
        add(1, 0,1,0,2'b11,1,1,0,1, 2'b10,1,0,0,1);
        add(2, 0,1,0,2'b11,1,0,0,0, 2'b11,1,0,0,1);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,1,0,0);
        add(1, 0,1,0,2'b11,1,0,0,0, 2'b11,0,0,0,0);

        @(posedge clk);
        #1;
        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r], r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
